// File: rtl/psa_reduce_ctrl.sv
// Sequencer that streams a block of memory words through a shared parallel
// sub-word adder and folds them into one 16-bit accumulator, one word per cycle.
module psa_reduce_ctrl #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       psa_a,
    output logic [15:0]       psa_b,
    output logic              psa_opcode,
    input  logic [15:0]       psa_sum
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  issued;
    logic              mode_q;
    logic [15:0]       acc;
    logic              rvalid;   // mem_rdata carries a requested word this cycle

    assign psa_a      = acc;
    assign psa_b      = mem_rdata;
    assign psa_opcode = mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            mem_re   <= 1'b0;
            mem_addr <= '0;
            addr     <= '0;
            cnt_q    <= '0;
            issued   <= '0;
            mode_q   <= 1'b0;
            acc      <= '0;
            rvalid   <= 1'b0;
        end else begin
            // NOTE: defaults first; a later non-blocking assignment in the same
            // cycle overrides them, which keeps done a one-cycle pulse.
            done   <= 1'b0;
            rvalid <= mem_re;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        if (count != '0) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            mode_q   <= mode;
                            cnt_q    <= count;
                            mem_re   <= 1'b1;
                            mem_addr <= base_addr;
                            addr     <= base_addr + 1'b1;
                            issued   <= CNT_W'(1);
                        end else begin
                            state  <= FIN;
                            done   <= 1'b1;
                            result <= '0;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        mem_re <= 1'b0;
                        rvalid <= 1'b0;
                    end else begin
                        if (rvalid) acc <= psa_sum;
                        if (issued == cnt_q) begin
                            state  <= DRAIN;
                            mem_re <= 1'b0;
                        end else begin
                            mem_addr <= addr;
                            addr     <= addr + 1'b1;
                            issued   <= issued + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rvalid <= 1'b0;
                    end else begin
                        // Last word arrives now; publish it together with done.
                        acc    <= psa_sum;
                        result <= psa_sum;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= FIN;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psa_reduce_ctrl.sv
// Scoreboard bench for psa_reduce_ctrl: behavioural memory and PSA models,
// expected addresses/results queued at stimulus time and popped on DUT output.
module tb_psa_reduce_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, mode;
    logic [15:0] base_addr;
    logic [7:0]  count;
    logic        busy, done, mem_re, psa_opcode;
    logic [15:0] result, mem_addr, mem_rdata, psa_a, psa_b, psa_sum;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, re_cnt = 0, busy_cnt = 0;
    logic [15:0] addr_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] last_result = 16'h0000;
    logic [15:0] mem [0:65535];

    psa_reduce_ctrl #(.ADDR_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .base_addr(base_addr), .count(count), .busy(busy), .done(done),
        .result(result), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .psa_a(psa_a), .psa_b(psa_b),
        .psa_opcode(psa_opcode), .psa_sum(psa_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns data one cycle after the read; junk otherwise.
    always @(posedge clk) mem_rdata <= mem_re ? mem[mem_addr] : 16'hDEAD;

    function automatic logic [15:0] psa_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic op);
        logic [15:0] r;
        if (!op) return a + b;
        for (int i = 0; i < 4; i++) begin
            int x, y, s;
            x = $signed(a[4*i +: 4]);
            y = $signed(b[4*i +: 4]);
            s = x + y;
            if (s > 7) s = 7;
            if (s < -8) s = -8;
            r[4*i +: 4] = 4'(s);
        end
        return r;
    endfunction

    always_comb psa_sum = psa_model(psa_a, psa_b, psa_opcode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every read and every done is matched against the queues.
    always @(negedge clk) begin
        if (mem_re) begin
            re_cnt++;
            if (addr_q.size() == 0) check("read_unexpected", mem_re, 1'b0);
            else check("mem_addr", mem_addr, addr_q.pop_front());
        end
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_q.size() == 0) check("done_unexpected", done, 1'b0);
            else check("result", result, exp_q.pop_front());
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},   busy,       1'b0);
        check({tag, "_done"},   done,       1'b0);
        check({tag, "_result"}, result,     16'h0000);
        check({tag, "_mem_re"}, mem_re,     1'b0);
        check({tag, "_addr"},   mem_addr,   16'h0000);
        check({tag, "_acc"},    psa_a,      16'h0000);
        check({tag, "_opcode"}, psa_opcode, 1'b0);
    endtask

    task automatic run_job(input logic m, input logic [15:0] b, input logic [15:0] data[$],
                           input logic with_abort);
        logic [15:0] acc = 16'h0000;
        int n = data.size();
        int d0, r0, b0, t0, lat;
        for (int i = 0; i < n; i++) begin
            logic [15:0] a = b + 16'(i);
            mem[a] = data[i];
            addr_q.push_back(a);
            acc = psa_model(acc, data[i], m);
        end
        exp_q.push_back(acc);
        lat = (n == 0) ? 1 : n + 2;
        @(negedge clk);
        #1;
        d0 = done_cnt; r0 = re_cnt; b0 = busy_cnt; t0 = cyc;
        start = 1'b1; abort = with_abort; mode = m; base_addr = b; count = 8'(n);
        @(negedge clk);
        start = 1'b0; abort = 1'b0; mode = ~m; base_addr = ~b; count = 8'hFF;
        for (int i = 0; i < 300 && done_cnt == d0; i++) begin
            @(negedge clk);
            #1;
        end
        if (done_cnt == d0) begin
            check("done_timeout", done_cnt, d0 + 1);
            void'(exp_q.pop_back());
        end else begin
            check("done_latency", done_cyc - t0, lat);
            check("read_count",   re_cnt - r0, n);
            check("busy_cycles",  busy_cnt - b0, (n == 0) ? 0 : n + 1);
            check("busy_at_done", busy, 1'b0);
            last_result = acc;
        end
        count = 8'h00;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d[$];
        int d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        base_addr = 16'h0000; count = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        d = '{16'h7777, 16'h7777};                 run_job(1'b1, 16'h0010, d, 1'b0);
        d = '{16'h8888, 16'h8888};                 run_job(1'b1, 16'h0040, d, 1'b0);
        d = '{16'h3333, 16'h3333};                 run_job(1'b1, 16'h0050, d, 1'b0);
        d = '{16'h1111, 16'h1111, 16'h1111};       run_job(1'b0, 16'h0020, d, 1'b0);
        d = {};                                    run_job(1'b0, 16'h0030, d, 1'b0);
        d = '{16'hFFFF, 16'h0002};                 run_job(1'b0, 16'hFFFF, d, 1'b0);

        // Abort at cycle 2 with an ignored second start at cycle 1.
        for (int i = 0; i < 4; i++) mem[16'h0100 + 16'(i)] = 16'h0F0F;
        addr_q.push_back(16'h0100);
        addr_q.push_back(16'h0101);
        @(negedge clk);
        d0 = done_cnt;
        start = 1'b1; mode = 1'b0; base_addr = 16'h0100; count = 8'd4;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; base_addr = 16'h0200; count = 8'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_busy",   busy,   1'b0);
        check("abort_mem_re", mem_re, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        check("abort_no_done", done_cnt, d0);
        check("abort_result",  result,   last_result);

        // Start and abort together in IDLE: start wins; mixed-sign nibbles.
        d = '{16'h7A5C, 16'h39E4, 16'hC8F1};      run_job(1'b1, 16'h0060, d, 1'b1);
        d = '{16'h1234, 16'hF00F, 16'h0101};      run_job(1'b0, 16'h0070, d, 1'b0);

        // Synchronous reset in the middle of a job.
        mem[16'h0300] = 16'h1111; mem[16'h0301] = 16'h2222;
        addr_q.push_back(16'h0300);
        addr_q.push_back(16'h0301);
        @(negedge clk);
        d0 = done_cnt;
        start = 1'b1; mode = 1'b1; base_addr = 16'h0300; count = 8'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (8) @(negedge clk);
        #1;
        check("midrst_no_done", done_cnt, d0);
        last_result = 16'h0000;

        d = {};
        for (int i = 0; i < 10; i++) d.push_back(16'($urandom));
        run_job(1'b1, 16'($urandom), d, 1'b0);
        d = {};
        for (int i = 0; i < 7; i++) d.push_back(16'($urandom));
        run_job(1'b0, 16'hFFFC, d, 1'b0);

        repeat (3) @(negedge clk);
        check("addr_queue_empty", addr_q.size(), 0);
        check("exp_queue_empty",  exp_q.size(),  0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/psa_reduce_ctrl.md
Name: psa_reduce_ctrl

Overview:
- Sequencer that drives one shared 16-bit parallel sub-word adder (PSA) to reduce a block of memory words into a single 16-bit accumulator.
- Streams COUNT consecutive words from a data-memory read port and folds each word into the accumulator through the PSA.
- Pipelined at one word per cycle.
- Used for checksum and vector-sum operations alongside the execute datapath.

Parameters:
- ADDR_W, 16, memory address width; addresses wrap modulo 2^ADDR_W.
- CNT_W, 8, width of the word-count input; max block = 2^CNT_W-1 words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  cancel an in-progress reduction.
- mode  input  1  PSA opcode for this job; latched at start.
- base_addr  input  ADDR_W  first word address; latched at start.
- count  input  CNT_W  number of words; latched at start.
- busy  output  1  high from the cycle after an accepted start until done/abort.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  16  final accumulator, held until the next done.
- mem_addr  output  ADDR_W  read address.
- mem_re  output  1  read enable.
- mem_rdata  input  16  read data, valid exactly 1 cycle after mem_re.
- psa_a  output  16  PSA operand A = accumulator.
- psa_b  output  16  PSA operand B = mem_rdata.
- psa_opcode  output  1  latched mode.
- psa_sum  input  16  PSA combinational result.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst); on rst, every state register clears.
- Reset values: state=IDLE, busy=0, done=0, result=0x0000, mem_re=0, mem_addr=0, accumulator=0, latched mode=0.
- PSA function (datapath contract):
  - opcode=1: four independent signed 4-bit nibble adds, each saturating to 0x7 or 0x8.
  - opcode=0: 16-bit modular add.
- PSA drive: psa_a, psa_b and psa_opcode are driven combinationally from the accumulator, mem_rdata and the latched mode in every state. The PSA is only consumed on accumulate cycles.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE, start=1 with count>0: latch inputs, clear accumulator, go to RUN. issued=0, addr=base.
- IDLE, start=1 with count=0: go to FIN. No reads; result becomes 0x0000.
- RUN:
  - Each cycle: mem_re=1, mem_addr=addr, addr+1 (wraps 0xFFFF->0x0000).
  - After the read numbered count is issued, go to DRAIN.
- Accumulate: every cycle after a mem_re=1 cycle, acc <= psa_sum. This applies in both RUN and DRAIN.
- DRAIN: mem_re=0; perform the last accumulate; go to FIN.
- FIN:
  - done=1 and result=acc, both registered so they are visible this cycle.
  - Next state IDLE.
  - busy=0 in FIN.
- Latency: start accepted at cycle 0. Reads occur in cycles 1..N. done is at cycle N+2 (count=0: done at cycle 1).
- start while busy: ignored, with no effect on the latched values.
- abort while busy (RUN or DRAIN):
  - Next state IDLE.
  - mem_re deasserts next cycle; no done; result unchanged.
  - Outstanding read data is discarded.
- abort in IDLE/FIN: no effect.
- Simultaneous start and abort in IDLE: start wins.
- rst mid-operation: immediate return to reset values at the next edge; no done.

Test Plan:
- mode=1, base=0x0010, count=2, mem=0x7777, 0x7777 -> mem_addr 0x0010, 0x0011; done at cycle 4; result 0x7777 (positive nibble saturation).
- mode=1, count=2, data 0x8888, 0x8888 -> result 0x8888 (negative saturation); data 0x3333, 0x3333 -> result 0x6666.
- mode=0, base=0x0020, count=3, data 0x1111 x3 -> mem_re high exactly 3 cycles; result 0x3333; busy high cycles 1..4.
- count=0 -> done at cycle 1; result 0x0000; mem_re never asserted.
- mode=0, base=0xFFFF, count=2, data 0xFFFF, 0x0002 -> addresses 0xFFFF, 0x0000; result 0x0001.
- start count=4, abort at cycle 2, second start at cycle 1 -> no done; result keeps its prior value; state IDLE at cycle 3; mem_re low from cycle 3.
